// File: rtl/cve2_rf_load_scoreboard.sv
// Integer register file (x0 hard-wired to zero) with two combinational read
// ports, one writeback port and a single-outstanding-load scoreboard that
// raises per-port stall requests while a load destination is in flight.
module cve2_rf_load_scoreboard #(
  parameter bit RV32E = 1'b0,
  parameter bit WrFwd = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        load_issue_i,
  input  logic [4:0]  load_rd_i,
  input  logic        load_done_i,
  input  logic        load_err_i,
  output logic        stall_a_o,
  output logic        stall_b_o,
  output logic        load_pending_o,
  output logic        proto_err_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  logic [31:0] regs_q [1:31];
  state_e      state_q, state_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic        proto_err_q, proto_err_d;
  logic        pend_q;
  logic        wr_en;

  // An erroring load clears the entry exactly like a good one; the error bit
  // only tells the core that no writeback will follow.
  logic        unused_load_err;
  assign unused_load_err = load_err_i;

  // Upper half of the address space does not exist in the embedded variant.
  function automatic logic addr_legal(input logic [4:0] addr);
    return !(RV32E && addr[4]);
  endfunction

  assign wr_en = we_i && (waddr_i != 5'd0) && addr_legal(waddr_i);

  // Architectural storage: x1..x31 flops, cleared on reset, written from writeback.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the register file is plain flops and must read as zero after
      // reset, so every entry is reset; a RAM-style array would not be.
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port A: zero for x0/illegal, then writeback forwarding, then storage.
  always_comb begin
    // NOTE: the default comes first so no path through the block leaves the
    // output unassigned, which would otherwise infer a latch.
    rdata_a_o = '0;
    if ((raddr_a_i != 5'd0) && addr_legal(raddr_a_i)) begin
      if (WrFwd && we_i && (waddr_i == raddr_a_i)) begin
        rdata_a_o = wdata_i;
      end else begin
        rdata_a_o = regs_q[raddr_a_i];
      end
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rdata_b_o = '0;
    if ((raddr_b_i != 5'd0) && addr_legal(raddr_b_i)) begin
      if (WrFwd && we_i && (waddr_i == raddr_b_i)) begin
        rdata_b_o = wdata_i;
      end else begin
        rdata_b_o = regs_q[raddr_b_i];
      end
    end
  end

  // Scoreboard state register and sticky protocol error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pend_rd_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Scoreboard next state: track one load, flag overlapping issues and
  // completions that arrive with nothing outstanding.
  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      IDLE: begin
        if (load_done_i) begin
          proto_err_d = 1'b1;
        end
        if (load_issue_i) begin
          state_d   = PENDING;
          pend_rd_d = load_rd_i;
        end
      end
      PENDING: begin
        if (load_issue_i) begin
          // Back-to-back when the old load retires this cycle; otherwise a
          // second outstanding load, which the scoreboard cannot hold.
          pend_rd_d = load_rd_i;
          if (!load_done_i) begin
            proto_err_d = 1'b1;
          end
        end else if (load_done_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pend_q         = (state_q == PENDING);
  assign load_pending_o = pend_q;
  assign proto_err_o    = proto_err_q;

  // With forwarding the completing writeback is visible this cycle, so the
  // completion cycle itself need not stall.
  assign stall_a_o = pend_q && (pend_rd_q == raddr_a_i) && (raddr_a_i != 5'd0)
                     && !(WrFwd && load_done_i);
  assign stall_b_o = pend_q && (pend_rd_q == raddr_b_i) && (raddr_b_i != 5'd0)
                     && !(WrFwd && load_done_i);

endmodule

// File: tb/tb_cve2_rf_load_scoreboard.sv
// Self-checking bench for cve2_rf_load_scoreboard: three instances (default,
// no forwarding, RV32E) share one stimulus; each cycle's expectations are
// queued when driven and compared against the selected instance mid-cycle.
module tb_cve2_rf_load_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr_a, raddr_b, waddr, load_rd;
  logic [31:0] wdata;
  logic        we, load_issue, load_done, load_err;

  logic [31:0] rdata_a [3];
  logic [31:0] rdata_b [3];
  logic        stall_a [3];
  logic        stall_b [3];
  logic        pend    [3];
  logic        perr    [3];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cve2_rf_load_scoreboard #(.RV32E(1'b0), .WrFwd(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .raddr_a_i(raddr_a), .rdata_a_o(rdata_a[0]),
    .raddr_b_i(raddr_b), .rdata_b_o(rdata_b[0]),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .load_issue_i(load_issue), .load_rd_i(load_rd),
    .load_done_i(load_done), .load_err_i(load_err),
    .stall_a_o(stall_a[0]), .stall_b_o(stall_b[0]),
    .load_pending_o(pend[0]), .proto_err_o(perr[0])
  );

  cve2_rf_load_scoreboard #(.RV32E(1'b0), .WrFwd(1'b0)) dut_nofwd (
    .clk_i(clk), .rst_i(rst),
    .raddr_a_i(raddr_a), .rdata_a_o(rdata_a[1]),
    .raddr_b_i(raddr_b), .rdata_b_o(rdata_b[1]),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .load_issue_i(load_issue), .load_rd_i(load_rd),
    .load_done_i(load_done), .load_err_i(load_err),
    .stall_a_o(stall_a[1]), .stall_b_o(stall_b[1]),
    .load_pending_o(pend[1]), .proto_err_o(perr[1])
  );

  cve2_rf_load_scoreboard #(.RV32E(1'b1), .WrFwd(1'b1)) dut_rv32e (
    .clk_i(clk), .rst_i(rst),
    .raddr_a_i(raddr_a), .rdata_a_o(rdata_a[2]),
    .raddr_b_i(raddr_b), .rdata_b_o(rdata_b[2]),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .load_issue_i(load_issue), .load_rd_i(load_rd),
    .load_done_i(load_done), .load_err_i(load_err),
    .stall_a_o(stall_a[2]), .stall_b_o(stall_b[2]),
    .load_pending_o(pend[2]), .proto_err_o(perr[2])
  );

  // One cycle of stimulus plus the outputs expected during that cycle.
  typedef struct packed {
    logic [1:0]  sel;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        iss;
    logic [4:0]  rd;
    logic        done;
    logic        err;
    logic        chk;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        esa;
    logic        esb;
    logic        epend;
    logic        eperr;
  } vec_t;

  vec_t  exp_q [$];
  string lbl_q [$];
  vec_t  tbl [22];

  function automatic vec_t mk(input int sel, rst, we, wa, wd, ra, rb, iss, rd,
                              done, err, chk, ea, eb, esa, esb, epend, eperr);
    vec_t m;
    m.sel = 2'(sel);  m.rst = 1'(rst);   m.we = 1'(we);
    m.waddr = 5'(wa); m.wdata = 32'(wd);
    m.ra = 5'(ra);    m.rb = 5'(rb);
    m.iss = 1'(iss);  m.rd = 5'(rd);     m.done = 1'(done); m.err = 1'(err);
    m.chk = 1'(chk);  m.ea = 32'(ea);    m.eb = 32'(eb);
    m.esa = 1'(esa);  m.esb = 1'(esb);   m.epend = 1'(epend); m.eperr = 1'(eperr);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic compare(input vec_t v, input string l);
    int s;
    s = int'(v.sel);
    check({l, ".rdata_a"}, rdata_a[s], v.ea);
    check({l, ".rdata_b"}, rdata_b[s], v.eb);
    check({l, ".stall_a"}, {31'b0, stall_a[s]}, {31'b0, v.esa});
    check({l, ".stall_b"}, {31'b0, stall_b[s]}, {31'b0, v.esb});
    check({l, ".load_pending"}, {31'b0, pend[s]}, {31'b0, v.epend});
    check({l, ".proto_err"}, {31'b0, perr[s]}, {31'b0, v.eperr});
  endtask

  // Drive just after the rising edge, compare on the falling edge.
  task automatic step(input vec_t v, input string l);
    vec_t  got;
    string gl;
    rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata;
    raddr_a = v.ra; raddr_b = v.rb;
    load_issue = v.iss; load_rd = v.rd; load_done = v.done; load_err = v.err;
    if (v.chk) begin
      exp_q.push_back(v);
      lbl_q.push_back(l);
    end
    @(negedge clk);
    if (v.chk) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL %s: scoreboard empty, got nothing, expected an entry", l);
      end else begin
        got = exp_q.pop_front();
        gl  = lbl_q.pop_front();
        compare(got, gl);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst");
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    load_issue = 1'b0; load_rd = '0; load_done = 1'b0; load_err = 1'b0;

    //             sel rst we wa  wdata          ra rb iss rd dn er chk ea             eb             sa sb pd pe
    tbl[0]  = mk(0, 0, 0, 0,  0,             5, 0,  0, 0, 0, 0, 1, 0,             0,             0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 5,  32'hDEADBEEF,  1, 2,  0, 0, 0, 0, 1, 0,             0,             0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0,  0,             5, 0,  0, 0, 0, 0, 1, 32'hDEADBEEF,  0,             0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 7,  1,             7, 5,  0, 0, 0, 0, 1, 1,             32'hDEADBEEF,  0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 7,  'h55,          7, 7,  0, 0, 0, 0, 1, 'h55,          'h55,          0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,  0,             7, 0,  0, 0, 0, 0, 1, 'h55,          0,             0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0,  0,             0, 9,  1, 9, 0, 0, 1, 0,             0,             0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,  0,             9, 9,  0, 0, 0, 0, 1, 0,             0,             1, 1, 1, 0);
    tbl[8]  = mk(0, 0, 1, 9,  'hA5A5,        9, 9,  0, 0, 1, 0, 1, 'hA5A5,        'hA5A5,        0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0,  0,             9, 9,  0, 0, 0, 0, 1, 'hA5A5,        'hA5A5,        0, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 3,  'h10,          0, 0,  0, 0, 0, 0, 1, 0,             0,             0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0,  0,             3, 0,  1, 3, 0, 0, 1, 'h10,          0,             0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0,  0,             3, 0,  0, 0, 1, 1, 1, 'h10,          0,             0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0,  0,             3, 0,  0, 0, 0, 0, 1, 'h10,          0,             0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,  0,             0, 0,  1, 0, 0, 0, 1, 0,             0,             0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0,  0,             0, 0,  0, 0, 0, 0, 1, 0,             0,             0, 0, 1, 0);
    tbl[16] = mk(0, 0, 0, 0,  0,             0, 11, 1, 11, 1, 0, 1, 0,            0,             0, 0, 1, 0);
    tbl[17] = mk(0, 0, 0, 0,  0,             0, 11, 0, 0, 0, 0, 1, 0,             0,             0, 1, 1, 0);
    tbl[18] = mk(0, 0, 1, 11, 'h1234,        0, 11, 0, 0, 1, 0, 1, 0,             'h1234,        0, 0, 1, 0);
    tbl[19] = mk(0, 0, 0, 0,  0,             0, 11, 0, 0, 0, 0, 1, 0,             'h1234,        0, 0, 0, 0);
    tbl[20] = mk(0, 0, 1, 0,  'hFFFF,        0, 0,  0, 0, 0, 0, 1, 0,             0,             0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0,  0,             0, 5,  0, 0, 0, 0, 1, 0,             32'hDEADBEEF,  0, 0, 0, 0);

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 22; i++) begin
      step(tbl[i], $sformatf("tbl%0d", i));
    end

    // Second issue without completion: error, stall moves from x4 to x6.
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0), "pe_iss4");
    step(mk(0, 0, 0, 0, 0, 4, 6, 1, 6, 0, 0, 1, 0, 0, 1, 0, 1, 0), "pe_iss6");
    step(mk(0, 0, 0, 0, 0, 6, 4, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1), "pe_flag");
    step(mk(0, 0, 0, 0, 0, 6, 4, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1), "pe_done");
    step(mk(0, 0, 0, 0, 0, 6, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "pe_sticky");
    do_reset();
    // Completion with nothing outstanding.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), "sp_done");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "sp_flag");
    do_reset();
    // Reset with a load in flight drops it; the late response is spurious.
    step(mk(0, 0, 0, 0, 0, 8, 0, 1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0), "rm_iss");
    step(mk(0, 1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0), "rm_rst");
    step(mk(0, 0, 0, 0, 0, 8, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), "rm_done");
    step(mk(0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "rm_flag");

    // No forwarding: old value on the write cycle, stall through completion.
    do_reset();
    step(mk(1, 0, 1, 7, 1,      7, 0, 0, 0, 0, 0, 1, 0,      0, 0, 0, 0, 0), "nf_w1");
    step(mk(1, 0, 1, 7, 'h55,   7, 0, 0, 0, 0, 0, 1, 1,      0, 0, 0, 0, 0), "nf_w55");
    step(mk(1, 0, 0, 0, 0,      7, 0, 0, 0, 0, 0, 1, 'h55,   0, 0, 0, 0, 0), "nf_rd");
    step(mk(1, 0, 0, 0, 0,      9, 0, 1, 9, 0, 0, 1, 0,      0, 0, 0, 0, 0), "nf_iss");
    step(mk(1, 0, 0, 0, 0,      9, 0, 0, 0, 0, 0, 1, 0,      0, 1, 0, 1, 0), "nf_stall");
    step(mk(1, 0, 1, 9, 'hA5A5, 9, 0, 0, 0, 1, 0, 1, 0,      0, 1, 0, 1, 0), "nf_done");
    step(mk(1, 0, 0, 0, 0,      9, 0, 0, 0, 0, 0, 1, 'hA5A5, 0, 0, 0, 0, 0), "nf_after");

    // RV32E: upper registers absent; back-to-back loads keep tracking.
    do_reset();
    step(mk(2, 0, 1, 20, 'h77, 20, 0,  0, 0,  0, 0, 1, 0,    0, 0, 0, 0, 0), "e_w20");
    step(mk(2, 0, 0, 0,  0,    20, 0,  0, 0,  0, 0, 1, 0,    0, 0, 0, 0, 0), "e_r20");
    step(mk(2, 0, 1, 15, 'h77, 15, 0,  0, 0,  0, 0, 1, 'h77, 0, 0, 0, 0, 0), "e_w15");
    step(mk(2, 0, 0, 0,  0,    15, 0,  0, 0,  0, 0, 1, 'h77, 0, 0, 0, 0, 0), "e_r15");
    step(mk(2, 0, 0, 0,  0,    0,  0,  1, 5,  0, 0, 1, 0,    0, 0, 0, 0, 0), "e_iss5");
    step(mk(2, 0, 0, 0,  0,    0,  11, 1, 11, 1, 0, 1, 0,    0, 0, 0, 1, 0), "e_b2b");
    step(mk(2, 0, 0, 0,  0,    0,  11, 0, 0,  0, 0, 1, 0,    0, 0, 1, 1, 0), "e_stall11");
    step(mk(2, 0, 0, 0,  0,    0,  11, 0, 0,  1, 0, 1, 0,    0, 0, 0, 1, 0), "e_done");
    step(mk(2, 0, 0, 0,  0,    0,  11, 0, 0,  0, 0, 1, 0,    0, 0, 0, 0, 0), "e_idle");

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
